periferico_binario_abcd: RTL and testbench

PERIFERICO_BINARIO_ABCD -- requirements
Module: periferico_binario_abcd

---
 rtl/periferico_binario_abcd.sv | 131 +++++++++++++
 tb/tb_periferico_binario_abcd.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/periferico_binario_abcd.sv
// Memory-mapped binary to 4-digit BCD converter (shift-add-3).
// Results are committed on the edge after the last shift.
module periferico_binario_abcd (
  input  logic        CLK,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [5:0]  addr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ADJUST,
    SHIFT
  } state_t;

  state_t      state;
  logic [15:0] op_a;
  logic [15:0] snap;
  logic [15:0] work;
  logic [4:0]  cnt;
  logic [3:0]  unit;
  logic [3:0]  dec;
  logic [3:0]  cent;
  logic [3:0]  mil;
  logic        done;
  logic        ovf;
  logic        ovf_p;
  logic        commit;
  logic        start;
  logic [15:0] rdata;

  function automatic logic [15:0] add3(
    input logic [15:0] w
  );
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      if (w[i*4+:4] >= 4'd5)
        r[i*4+:4] = w[i*4+:4] + 4'd3;
      else
        r[i*4+:4] = w[i*4+:4];
    end
    return r;
  endfunction

  // commit still pending counts as busy
  assign start = cs && wr && (addr == 6'h08)
              && d_in[0] && (state == IDLE)
              && !commit;

  always_comb begin
    rdata = 16'h0;
    case (addr)
      6'h04:   rdata = op_a;
      6'h0C:   rdata = {12'h0, unit};
      6'h10:   rdata = {12'h0, dec};
      6'h14:   rdata = {12'h0, cent};
      6'h18:   rdata = {12'h0, mil};
      6'h1C:   rdata = {14'h0, ovf, done};
      default: rdata = 16'h0;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_a   <= 16'h0;
      snap   <= 16'h0;
      work   <= 16'h0;
      cnt    <= 5'd0;
      unit   <= 4'h0;
      dec    <= 4'h0;
      cent   <= 4'h0;
      mil    <= 4'h0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      ovf_p  <= 1'b0;
      commit <= 1'b0;
      d_out  <= 16'h0;
    end else begin
      if (cs && rd)
        d_out <= rdata;
      if (cs && wr && addr == 6'h04)
        op_a <= d_in;
      commit <= 1'b0;
      if (commit) begin
        unit <= work[3:0];
        dec  <= work[7:4];
        cent <= work[11:8];
        mil  <= work[15:12];
        ovf  <= ovf_p;
        done <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            done  <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          snap  <= op_a;
          work  <= 16'h0;
          cnt   <= 5'd16;
          ovf_p <= op_a > 16'd9999;
          state <= ADJUST;
        end
        ADJUST: begin
          work  <= add3(work);
          state <= SHIFT;
        end
        SHIFT: begin
          {work, snap} <= {work[14:0], snap, 1'b0};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state  <= IDLE;
            commit <= 1'b1;
          end else begin
            state <= ADJUST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periferico_binario_abcd.sv
// Bench for periferico_binario_abcd: random bus traffic checked
// against an arithmetic register model, plus literal pins.
module tb_periferico_binario_abcd;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [5:0]  addr = 6'h0;
  logic [15:0] d_in = 16'h0;
  logic [15:0] d_out;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  periferico_binario_abcd dut (
    .CLK   (CLK),
    .reset (reset),
    .cs    (cs),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .d_in  (d_in),
    .d_out (d_out)
  );

  always #5 CLK = ~CLK;

  int unsigned m_op   = 0;
  int unsigned m_snap = 0;
  int unsigned m_res  = 0;
  bit          m_done = 0;
  bit          m_ovf  = 0;
  int          m_busy = 0;
  logic [15:0] m_dout = 16'h0;

  function automatic logic [15:0] m_read(input logic [5:0] a);
    case (a)
      6'h04:   return 16'(m_op);
      6'h0C:   return 16'(m_res % 10);
      6'h10:   return 16'((m_res / 10) % 10);
      6'h14:   return 16'((m_res / 100) % 10);
      6'h18:   return 16'(m_res / 1000);
      6'h1C:   return {14'h0, m_ovf, m_done};
      default: return 16'h0;
    endcase
  endfunction

  // Conversion seen as: snapshot one edge after INIT,
  // result snap%10000 visible 34 edges after INIT.
  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      m_op = 0; m_snap = 0; m_res = 0;
      m_done = 0; m_ovf = 0; m_busy = 0;
      m_dout = 16'h0;
    end else begin
      bit idle;
      idle = (m_busy == 0);
      if (cs && rd)
        m_dout = m_read(addr);
      if (m_busy == 34)
        m_snap = m_op;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_res  = m_snap % 10000;
          m_ovf  = m_snap > 9999;
          m_done = 1;
        end
      end
      if (cs && wr) begin
        if (addr == 6'h04)
          m_op = d_in;
        if (addr == 6'h08 && d_in[0] && idle) begin
          m_busy = 34;
          m_done = 0;
        end
      end
    end
  end

  always @(posedge CLK) begin
    #2;
    if (cmp_en) begin
      checks++;
      if (d_out !== m_dout) begin
        failures++;
        $display("FAIL dout t=%0t got=%h exp=%h",
                 $time, d_out, m_dout);
      end
    end
  end

  task automatic bus(input logic c, input logic r,
                     input logic w, input logic [5:0] a,
                     input logic [15:0] d);
    @(negedge CLK);
    cs = c; rd = r; wr = w; addr = a; d_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      bus(0, 0, 0, 6'h0, 16'h0);
  endtask

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a,
                        input logic [15:0] exp);
    bus(1, 1, 0, a, 16'h0);
    @(posedge CLK);
    #3;
    chk(name, d_out, exp);
  endtask

  task automatic wr_reg(input logic [5:0] a, input logic [15:0] d);
    bus(1, 0, 1, a, d);
  endtask

  // Start a conversion and poll STATUS; DONE set on edge 34
  // appears in d_out on the read at edge 35.
  task automatic convert(input logic [15:0] op);
    int n;
    wr_reg(6'h04, op);
    wr_reg(6'h08, 16'h1);
    n = 0;
    for (int i = 1; i <= 60 && n == 0; i++) begin
      bus(1, 1, 0, 6'h1C, 16'h0);
      @(posedge CLK);
      #3;
      if (d_out[0]) n = i;
    end
    chk("done_latency", 16'(n), 16'd35);
  endtask

  task automatic digits(input string nm, input logic [3:0] m,
                        input logic [3:0] c, input logic [3:0] d,
                        input logic [3:0] u, input logic [15:0] st);
    rd_chk({nm, "_unit"}, 6'h0C, {12'h0, u});
    rd_chk({nm, "_dec"}, 6'h10, {12'h0, d});
    rd_chk({nm, "_cent"}, 6'h14, {12'h0, c});
    rd_chk({nm, "_mil"}, 6'h18, {12'h0, m});
    rd_chk({nm, "_status"}, 6'h1C, st);
  endtask

  initial begin
    #1;
    chk("reset_dout", d_out, 16'h0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    cmp_en = 1'b1;
    rd_chk("reset_status", 6'h1C, 16'h0);

    convert(16'd1234);
    digits("d1234", 1, 2, 3, 4, 16'h0001);
    convert(16'd0);
    digits("d0", 0, 0, 0, 0, 16'h0001);
    convert(16'd9999);
    digits("d9999", 9, 9, 9, 9, 16'h0001);
    convert(16'hFFFF);
    digits("dffff", 5, 5, 3, 5, 16'h0003);

    wr_reg(6'h04, 16'd1234);
    wr_reg(6'h08, 16'h1);
    idle(8);
    wr_reg(6'h04, 16'd42);
    wr_reg(6'h08, 16'h1);
    idle(40);
    digits("busy_init", 1, 2, 3, 4, 16'h0001);
    wr_reg(6'h08, 16'h0);
    idle(40);
    rd_chk("init0_status", 6'h1C, 16'h0001);
    wr_reg(6'h08, 16'h1);
    idle(40);
    digits("d42", 0, 0, 4, 2, 16'h0001);

    wr_reg(6'h04, 16'd1234);
    wr_reg(6'h08, 16'h1);
    idle(14);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("async_dout", d_out, 16'h0);
    idle(2);
    @(negedge CLK);
    reset = 1'b1;
    idle(40);
    rd_chk("rst_opa", 6'h04, 16'h0);
    digits("rst", 0, 0, 0, 0, 16'h0000);
    convert(16'd7);
    rd_chk("d7_unit", 6'h0C, 16'd7);

    rd_chk("addr00", 6'h00, 16'h0);
    rd_chk("addr20", 6'h20, 16'h0);
    rd_chk("addr3c", 6'h3C, 16'h0);
    wr_reg(6'h04, 16'hABCD);
    rd_chk("opa_rb", 6'h04, 16'hABCD);
    bus(1, 1, 1, 6'h04, 16'h1111);
    @(posedge CLK);
    #3;
    chk("rw_prewrite", d_out, 16'hABCD);

    for (int i = 0; i < 3000; i++) begin
      logic [5:0] a;
      logic [15:0] d;
      int r;
      r = $urandom_range(0, 9);
      a = (r < 7) ? 6'(4 * (r + 1)) : 6'($urandom);
      d = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = 16'($urandom_range(0, 9999));
      if ($urandom_range(0, 999) == 0) begin
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
      end
      bus(1'($urandom_range(0, 3) != 0),
          1'($urandom), 1'($urandom_range(0, 2) == 0), a, d);
    end
    idle(40);
    for (int a = 0; a < 64; a += 4) begin
      bus(1, 1, 0, 6'(a), 16'h0);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
